// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multicycle MIPS datapath
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic       is_lw_q, is_lw_d;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       decode_illegal;
    logic       ir_write_c, mem_write_c, reg_write_c, pc_write_c, branch_c;
    logic       instr_done_c, illegal_c;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100100: funct_alu = 3'b000;
            6'b100110: funct_alu = 3'b001;
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b100;
            6'b011000: funct_alu = 3'b101;
            6'b101010: funct_alu = 3'b110;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        decode_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_illegal = 1'b0;
            OP_RTYPE:                            decode_illegal = !funct_ok;
            default:                             decode_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        is_lw_d = is_lw_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                // lw/sw is remembered here so MEMADR never looks at the opcode again
                is_lw_d = (opcode == OP_LW);
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? S_EXEC : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = is_lw_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

    always_comb begin
        ir_write_c   = 1'b0;
        iord         = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg   = 1'b0;
        reg_dst      = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_control  = 3'b000;
        pc_src       = 2'b00;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_c  = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                pc_write_c  = 1'b1;
            end
            S_DECODE: begin
                alu_src_b    = 2'b11;
                alu_control  = 3'b010;
                illegal_c    = decode_illegal;
                instr_done_c = decode_illegal;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg   = 1'b1;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                mem_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            S_ALUWB: begin
                reg_dst      = 1'b1;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_control  = 3'b100;
                pc_src       = 2'b01;
                branch_c     = 1'b1;
                instr_done_c = 1'b1;
            end
            S_ADDIWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write_c   = 1'b1;
                instr_done_c = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked by rst_n so nothing writes while reset is held, even in FETCH
    assign ir_write   = ir_write_c & rst_n;
    assign mem_write  = mem_write_c & rst_n;
    assign reg_write  = reg_write_c & rst_n;
    assign pc_en      = (pc_write_c | (branch_c & zero_flag)) & rst_n;
    assign instr_done = instr_done_c & rst_n;
    assign illegal_op = illegal_c & rst_n;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero_flag;
    logic       ir_write, iord, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       pc_en, instr_done, illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [20:0] vec;
        string       tag;
    } sb_t;
    sb_t exp_q[$];

    logic [5:0] fn_tab  [6] = '{6'b100100, 6'b100110, 6'b100000, 6'b100010, 6'b011000, 6'b101010};
    logic [2:0] alu_tab [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
        .ir_write(ir_write), .iord(iord), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    wire [20:0] dut_vec = {state, ir_write, iord, mem_write, mem_to_reg, reg_dst, reg_write,
                           alu_src_a, alu_src_b, alu_control, pc_src, pc_en, instr_done, illegal_op};

    function automatic logic fn_legal(input logic [5:0] fn);
        fn_legal = 1'b0;
        for (int i = 0; i < 6; i++) if (fn_tab[i] == fn) fn_legal = 1'b1;
    endfunction

    function automatic logic op_illegal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b001000 || op == 6'b000010)
            op_illegal = 1'b0;
        else if (op == 6'b000000)
            op_illegal = !fn_legal(fn);
        else
            op_illegal = 1'b1;
    endfunction

    function automatic logic [20:0] exp_vec(input int st, input logic [5:0] op, input logic [5:0] fn,
                                            input logic zf);
        logic irw = 0, io = 0, mw = 0, m2r = 0, rd = 0, rw = 0, a = 0, pcw = 0, br = 0, dn = 0, il = 0;
        logic [1:0] b = 2'b00, pcs = 2'b00;
        logic [2:0] alu = 3'b000;
        case (st)
            0:  begin irw = 1; b = 2'b01; alu = 3'b010; pcw = 1; end
            1:  begin b = 2'b11; alu = 3'b010; il = op_illegal(op, fn); dn = il; end
            2:  begin a = 1; b = 2'b10; alu = 3'b010; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; dn = 1; end
            5:  begin io = 1; mw = 1; dn = 1; end
            6:  begin a = 1; for (int i = 0; i < 6; i++) if (fn_tab[i] == fn) alu = alu_tab[i]; end
            7:  begin rd = 1; rw = 1; dn = 1; end
            8:  begin a = 1; alu = 3'b100; pcs = 2'b01; br = 1; dn = 1; end
            9:  begin a = 1; b = 2'b10; alu = 3'b010; end
            10: begin rw = 1; dn = 1; end
            11: begin pcs = 2'b10; pcw = 1; dn = 1; end
            default: ;
        endcase
        exp_vec = {st[3:0], irw, io, mw, m2r, rd, rw, a, b, alu, pcs, pcw | (br & zf), dn, il};
    endfunction

    localparam logic [20:0] RESET_VEC = {4'd0, 7'b0, 2'b01, 3'b010, 2'b00, 3'b000};

    task automatic cmp(input logic [20:0] e, input string tag);
        #1;
        checks++;
        assert (dut_vec === e)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, dut_vec, e);
        end
    endtask

    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                       input int limit, input bit advance_last, input string name);
        int  st[$];
        sb_t s;
        opcode = op; funct = fn; zero_flag = zf;
        st = '{0, 1};
        if (!op_illegal(op, fn)) begin
            case (op)
                6'b100011: st = '{0, 1, 2, 3, 4};
                6'b101011: st = '{0, 1, 2, 5};
                6'b000000: st = '{0, 1, 6, 7};
                6'b000100: st = '{0, 1, 8};
                6'b001000: st = '{0, 1, 9, 10};
                6'b000010: st = '{0, 1, 11};
                default: ;
            endcase
        end
        for (int i = 0; i < st.size() && i < limit; i++) begin
            s.vec = exp_vec(st[i], op, fn, zf);
            s.tag = $sformatf("%s_s%0d", name, st[i]);
            exp_q.push_back(s);
        end
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            cmp(s.vec, s.tag);
            if (exp_q.size() > 0 || advance_last) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; opcode = 6'b100011; funct = 6'b0; zero_flag = 1'b1;
        repeat (3) begin
            @(negedge clk);
            cmp(RESET_VEC, "reset_hold");
        end
        rst_n = 1'b1;

        run(6'b100011, 6'h00, 1'($urandom_range(0, 1)), 99, 1, "lw");
        run(6'b101011, 6'h00, 1'($urandom_range(0, 1)), 99, 1, "sw");
        for (int i = 0; i < 6; i++)
            run(6'b000000, fn_tab[i], 1'($urandom_range(0, 1)), 99, 1, $sformatf("rtype%0d", i));
        run(6'b001000, 6'h00, 1'($urandom_range(0, 1)), 99, 1, "addi");
        run(6'b000100, 6'h00, 1'b1, 99, 1, "beq_taken");
        run(6'b000100, 6'h00, 1'b0, 99, 1, "beq_not");
        run(6'b000010, 6'h00, 1'b0, 99, 1, "jump");
        run(6'b111111, 6'h00, 1'b0, 99, 1, "illegal_op");
        run(6'b000000, 6'b100001, 1'b0, 99, 1, "illegal_fn");

        run(6'b100011, 6'h00, 1'b0, 4, 0, "lw_mid");
        rst_n = 1'b0;
        cmp(RESET_VEC, "midrst_async");
        @(posedge clk);
        @(negedge clk);
        cmp(RESET_VEC, "midrst_hold");
        rst_n = 1'b1;
        run(6'b001000, 6'h00, 1'b1, 99, 1, "after_rst");
        run(6'b100011, 6'h00, 1'b0, 99, 1, "lw2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS datapath. Decodes the registered instruction's `opcode`/`funct`, walks a Moore state machine through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select. It is the producer of `alu_control`, using the same 3-bit encoding the ALU already consumes, and it consumes the ALU's `zero_flag` for branches.

## Interface
Parameters:
- None. All encodings below are fixed.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0] from the instruction register.
- `zero_flag`  in  1  ALU zero output.
- `ir_write`  out  1  load the instruction register.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  memory write enable.
- `mem_to_reg`  out  1  register write data select: 0 = ALUOut, 1 = data register.
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_control`  out  3  ALU operation: 000 AND, 001 XOR, 010 ADD, 100 SUB, 101 MUL, 110 SLT.
- `pc_src`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_en`  out  1  PC load enable, equal to `pc_write | (branch & zero_flag)`.
- `instr_done`  out  1  high during the final state of each instruction.
- `illegal_op`  out  1  one-cycle pulse in DECODE when the opcode or funct is unsupported.
- `state`  out  4  current state encoding, for debug.

## Operation
- State encoding: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11. Codes 12–15 go to FETCH.
- Outputs are Moore functions of `state`. Two exceptions:
  - In EXEC, `alu_control` is also decoded from `funct`.
  - `pc_en` also depends on `zero_flag`.
- Any output not listed for a state is 0.
- Per-state outputs and transitions:
  - FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_control=010, pc_src=00, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target into ALUOut). Next by opcode:
    - 100011 (lw) or 101011 (sw): MEMADR.
    - 000000 (R-type): EXEC.
    - 000100 (beq): BRANCH.
    - 001000 (addi): ADDIEX.
    - 000010 (j): JUMP.
    - Anything else: FETCH, with illegal_op=1 and instr_done=1.
    - R-type with unsupported funct: FETCH, with illegal_op=1 and instr_done=1.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_control=010. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: iord=1. Next: MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWR: iord=1, mem_write=1, instr_done=1. Next: FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00. `funct` to `alu_control`:
    - 100100 → 000 (AND)
    - 100110 → 001 (XOR)
    - 100000 → 010 (ADD)
    - 100010 → 100 (SUB)
    - 011000 → 101 (MUL, low 32 bits)
    - 101010 → 110 (SLT)
    - Next: ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_control=100, pc_src=01, branch=1, instr_done=1. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=010. Next: ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next: FETCH.
  - JUMP: pc_src=10, pc_write=1, instr_done=1. Next: FETCH.

## Timing
- Reset:
  - While `rst_n`=0, `state`=FETCH (0).
  - `ir_write`, `mem_write`, `reg_write`, `pc_en`, `instr_done` and `illegal_op` are all forced to 0.
  - Selects and `alu_control` take their FETCH values.
- The first fetch completes on the first rising edge after `rst_n` deasserts.
- Asserting `rst_n` in any state returns the block to FETCH immediately, without waiting for a clock. No partial writeback occurs after assertion.
- Cycles per instruction, FETCH through the `instr_done` cycle: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- `opcode`/`funct` are sampled only in DECODE and EXEC. The IR changes only at the end of FETCH, so these inputs are stable there.
- `pc_en` in BRANCH is combinational on `zero_flag` within the same cycle. The PC loads at the end of BRANCH only when `zero_flag`=1.
- Exactly one `instr_done` pulse per instruction. `illegal_op` coincides with that instruction's `instr_done`.

## Test plan
- Reset: hold `rst_n`=0 across 3 clocks, release. Required:
  - `state`=0, all enables 0 during reset.
  - Next cycle after release: FETCH outputs, then `state`=1.
- lw: `opcode`=100011. Required:
  - State sequence 0,1,2,3,4,0.
  - MEMWB has reg_write=1 and mem_to_reg=1.
  - `instr_done` only in state 4.
- R-type sweep: `opcode`=0, each supported funct in turn. Required:
  - EXEC `alu_control` = 000, 001, 010, 100, 101, 110 for the six funct codes.
  - ALUWB has reg_dst=1.
  - 4 cycles per instruction.
- beq: `opcode`=000100, once with `zero_flag`=1 and once with `zero_flag`=0. Required:
  - BRANCH has `pc_en`=1 when taken, `pc_en`=0 when not taken.
  - `alu_control`=100 and `pc_src`=01 in both cases.
  - 3 cycles.
- sw and j:
  - sw: MEMWR has mem_write=1 and iord=1, with reg_write=0 throughout.
  - j: JUMP has pc_src=10 and `pc_en`=1.
- Illegal and mid-op reset:
  - `opcode`=111111: `illegal_op`=1 in DECODE, then FETCH. No reg_write or mem_write at any point.
  - Assert `rst_n`=0 in MEMRD: `state`=0 immediately, with no reg_write afterwards.
